// File: rtl/oam_dma_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : oam_dma_ctrl
//  Description : FF46 OAM DMA controller. A CPU write to FF46 selects a source
//                page; after a one-cycle START phase the block walks 160
//                bytes ({SRCM, 00..9F}) with one OAM write strobe per cycle.
//                Source pages E0-FF mirror C0-DF.
//  Revision    : 1.0 - initial release
// ============================================================================
module oam_dma_ctrl (
  input  logic        clk,
  input  logic        nreset,
  input  logic        reg_wr,
  input  logic        reg_rd,
  input  logic [7:0]  d,
  output logic [7:0]  q,
  output logic        dma_run,
  output logic [15:0] dma_a,
  output logic        vram_to_oam,
  output logic        oam_addr_ndma,
  output logic        oam_wr,
  output logic        dma_done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  localparam logic [7:0] c_LAST_BYTE = 8'd159;
  localparam logic [7:0] c_VRAM_LO   = 8'h80;
  localparam logic [7:0] c_VRAM_HI   = 8'h9F;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q,   cnt_d;
  logic [7:0]  src_q,   src_d;
  logic [7:0]  rsrc_q,  rsrc_d;
  logic        run_q,   run_d;
  logic        wr_q,    wr_d;
  logic        v2o_q,   v2o_d;
  logic [15:0] addr_q,  addr_d;
  logic [7:0]  w_srcm_d;

  // Echo-RAM pages E0-FF fold onto C0-DF by clearing bit 5.
  function automatic logic [7:0] mirror(input logic [7:0] s);
    return (s[7:5] == 3'b111) ? (s & 8'hDF) : s;
  endfunction

  // Next-state and next-output computation for the transfer sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    src_d   = reg_wr ? d : src_q;
    // Every write starts (or restarts) a transfer, so the run source follows it.
    rsrc_d  = reg_wr ? d : rsrc_q;

    case (state_q)
      ST_IDLE: begin
        if (reg_wr) state_d = ST_START;
      end
      ST_START: begin
        if (!reg_wr) begin
          state_d = ST_RUN;
          cnt_d   = 8'd0;
        end
      end
      ST_RUN: begin
        if (reg_wr) begin
          state_d = ST_START;
        end else if (cnt_q == c_LAST_BYTE) begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
      end
    endcase

    w_srcm_d = mirror(rsrc_d);
    // START keeps the previous run flag: low on a first start, high on a restart.
    run_d    = (state_d == ST_RUN) ? 1'b1 :
               (state_d == ST_IDLE) ? 1'b0 : run_q;
    wr_d     = (state_d == ST_RUN);
    // The address only advances in RUN; START and IDLE hold the last byte address.
    addr_d   = (state_d == ST_RUN) ? {w_srcm_d, cnt_d} : addr_q;
    v2o_d    = run_d && (w_srcm_d >= c_VRAM_LO) && (w_srcm_d <= c_VRAM_HI);
  end

  // State and registered outputs, cleared asynchronously by nreset.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      src_q   <= 8'h00;
      rsrc_q  <= 8'h00;
      run_q   <= 1'b0;
      wr_q    <= 1'b0;
      v2o_q   <= 1'b0;
      addr_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      rsrc_q  <= rsrc_d;
      run_q   <= run_d;
      wr_q    <= wr_d;
      v2o_q   <= v2o_d;
      addr_q  <= addr_d;
    end
  end

  // Readback shows the stored value, so a same-cycle write is visible next cycle.
  assign q             = reg_rd ? src_q : 8'h00;
  assign dma_run       = run_q;
  assign oam_addr_ndma = ~run_q;
  assign oam_wr        = wr_q;
  assign dma_a         = addr_q;
  assign vram_to_oam   = v2o_q;
  // Done depends on the write strobe of the closing edge, so it cannot be registered.
  assign dma_done      = (state_q == ST_RUN) && (cnt_q == c_LAST_BYTE) && !reg_wr;

endmodule
`default_nettype wire
